// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC sequencing, credit-limited imem requests, in-order response queue to decode.
// Optional FETCH_PERF_EN adds perf_fetch_cnt / perf_stall_cnt outputs.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
`ifdef FETCH_PERF_EN
    output logic [31:0] id_instr,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`else
    output logic [31:0] id_instr
`endif
);

    localparam int            CW        = $clog2(QDEPTH + 1);
    localparam int            PW        = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int            UW        = CW + 2;
    localparam logic [UW-1:0] CREDITS   = UW'(QDEPTH);
    localparam logic [PW-1:0] LAST_SLOT = PW'(QDEPTH - 1);
    localparam logic [31:0]   NOP       = 32'h0000_0013;

    logic [31:0]   pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] out_cnt;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] q_cnt;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [31:0]   q_pc    [QDEPTH];
    logic [31:0]   q_instr [QDEPTH];

    logic          pop;
    logic          accept;
    logic          rsp_drop;
    logic          rsp_take;
    logic          rsp_any;
    logic          push;
    logic [UW-1:0] used;

    function automatic logic [PW-1:0] next_slot(input logic [PW-1:0] slot);
        return (slot == LAST_SLOT) ? '0 : slot + 1'b1;
    endfunction

    // A word popped this cycle frees its credit immediately, which keeps 1 instr/cycle at QDEPTH=2.
    always_comb begin
        pop      = id_valid && id_ready;
        used     = UW'(out_cnt) + UW'(drop_cnt) + UW'(q_cnt) - UW'(pop);
        imem_req = !rst && !redirect_valid && (used < CREDITS);
        accept   = imem_req && imem_ready;
        rsp_drop = imem_rvalid && (drop_cnt != '0);
        rsp_take = imem_rvalid && (drop_cnt == '0) && (out_cnt != '0);
        rsp_any  = rsp_drop || rsp_take;
        push     = rsp_take && !redirect_valid;
    end

    always_comb begin
        imem_addr = pc & ~32'h0000_0003;
        id_valid  = (q_cnt != '0);
        id_pc     = id_valid ? q_pc[head] : 32'h0000_0000;
        id_instr  = id_valid ? q_instr[head] : NOP;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            resp_pc  <= RESET_PC;
            out_cnt  <= '0;
            drop_cnt <= '0;
            q_cnt    <= '0;
            head     <= '0;
            tail     <= '0;
        end else if (redirect_valid) begin
            // Every request still in flight now belongs to the wrong path and must be swallowed.
            pc       <= redirect_pc;
            resp_pc  <= redirect_pc;
            drop_cnt <= drop_cnt + out_cnt - CW'(rsp_any);
            out_cnt  <= '0;
            q_cnt    <= '0;
            head     <= '0;
            tail     <= '0;
        end else begin
            if (accept) begin
                pc <= pc + 32'd4;
            end
            if (push) begin
                resp_pc <= resp_pc + 32'd4;
                tail    <= next_slot(tail);
            end
            if (pop) begin
                head <= next_slot(head);
            end
            if (rsp_drop) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
            out_cnt <= out_cnt + CW'(accept) - CW'(rsp_take);
            q_cnt   <= q_cnt + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[tail]    <= resp_pc;
            q_instr[tail] <= imem_rdata;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt <= 32'h0;
            perf_stall_cnt <= 32'h0;
        end else begin
            if (pop) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (id_valid && !id_ready) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

`ifndef SYNTHESIS
    rsp_without_request: assert property (@(posedge clk) disable iff (rst)
        imem_rvalid |-> (out_cnt != '0 || drop_cnt != '0));
    credit_bound: assert property (@(posedge clk) disable iff (rst)
        (UW'(out_cnt) + UW'(drop_cnt) + UW'(q_cnt)) <= CREDITS);
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized bench for fetch_stage against an in-order memory model and expected PC stream.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
        .clk(clk),
        .rst(rst),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .id_valid(id_valid),
        .id_ready(id_ready),
        .id_pc(id_pc),
`ifdef FETCH_PERF_EN
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_stall_cnt(perf_stall_cnt),
`endif
        .id_instr(id_instr)
    );

    int total;
    int bad;

    // Memory model: accepted addresses with the cycle their response is due, returned in order.
    int          due_q[$];
    logic [31:0] addr_q[$];
    int          cyc;
    int          last_due;

    int          lat_lo, lat_hi, rdy_pct, idr_pct, redir_pm;
    bit          force_redir;
    logic [31:0] force_target;

    logic [31:0] exp_pc, fetch_pc, last_pop_pc;
    bit          popped;
    bit          prev_stall, prev_redir;
    logic [31:0] prev_pc, prev_instr;
    bit          s_valid, s_req;
    logic [31:0] s_pc;
    int          perf_pops, perf_stalls;
    logic [31:0] got_pc;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0013;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_clear();
        due_q.delete();
        addr_q.delete();
        cyc         = 0;
        last_due    = -1;
        exp_pc      = 32'h0;
        fetch_pc    = 32'h0;
        prev_stall  = 1'b0;
        prev_redir  = 1'b0;
        perf_pops   = 0;
        perf_stalls = 0;
    endtask

    // Entered at a falling edge; leaves reset released at a falling edge.
    task automatic do_reset();
        rst            = 1'b1;
        imem_rvalid    = 1'b0;
        imem_ready     = 1'b0;
        redirect_valid = 1'b0;
        id_ready       = 1'b0;
        #1;
        check("rst_imem_req", 32'(imem_req), 32'h0);
        check("rst_id_valid", 32'(id_valid), 32'h0);
        check("rst_id_pc", id_pc, 32'h0);
        check("rst_id_instr", id_instr, 32'h0000_0013);
`ifdef FETCH_PERF_EN
        check("rst_perf_fetch", perf_fetch_cnt, 32'h0);
        check("rst_perf_stall", perf_stall_cnt, 32'h0);
`endif
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One clock cycle: drive at the falling edge, sample 1 time unit later, advance the model.
    task automatic step();
        int d;
        imem_rvalid    = (due_q.size() > 0) && (due_q[0] <= cyc);
        imem_rdata     = imem_rvalid ? word_of(addr_q[0]) : 32'hDEAD_BEEF;
        imem_ready     = (int'($urandom_range(0, 99)) < rdy_pct);
        id_ready       = (int'($urandom_range(0, 99)) < idr_pct);
        redirect_valid = force_redir || (int'($urandom_range(0, 999)) < redir_pm);
        redirect_pc    = force_redir ? force_target : 32'h0000_1000 + 32'($urandom_range(0, 63)) * 32'd4;
        #1;
`ifdef FETCH_PERF_EN
        check("perf_fetch", perf_fetch_cnt, 32'(perf_pops));
        check("perf_stall", perf_stall_cnt, 32'(perf_stalls));
`endif
        if (prev_redir) begin
            check("flush_valid", 32'(id_valid), 32'h0);
        end else if (prev_stall) begin
            check("hold_valid", 32'(id_valid), 32'h1);
            check("hold_pc", id_pc, prev_pc);
            check("hold_instr", id_instr, prev_instr);
        end
        check("credit_ok", 32'(addr_q.size() <= 2), 32'h1);
        if (imem_rvalid) begin
            void'(due_q.pop_front());
            void'(addr_q.pop_front());
        end
        if (id_valid && id_ready) perf_pops++;
        if (id_valid && !id_ready) perf_stalls++;
        popped = 1'b0;
        if (redirect_valid) begin
            check("req_in_redirect", 32'(imem_req), 32'h0);
            exp_pc   = redirect_pc;
            fetch_pc = redirect_pc;
        end else begin
            if (imem_req) begin
                check("imem_addr", imem_addr, fetch_pc);
                if (imem_ready) begin
                    d = cyc + int'($urandom_range(lat_lo, lat_hi));
                    if (d <= last_due) d = last_due + 1;
                    last_due = d;
                    due_q.push_back(d);
                    addr_q.push_back(imem_addr);
                    fetch_pc += 32'd4;
                end
            end
            if (id_valid && id_ready) begin
                check("id_pc", id_pc, exp_pc);
                check("id_instr", id_instr, word_of(exp_pc));
                last_pop_pc = id_pc;
                exp_pc += 32'd4;
                popped = 1'b1;
            end
        end
        prev_redir  = redirect_valid;
        prev_stall  = id_valid && !id_ready;
        prev_pc     = id_pc;
        prev_instr  = id_instr;
        s_valid     = id_valid;
        s_pc        = id_pc;
        s_req       = imem_req;
        force_redir = 1'b0;
        cyc++;
        @(negedge clk);
    endtask

    task automatic wait_pop(input string tag, output logic [31:0] pc_o);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!popped && n < 60);
        check({tag, "_pop_seen"}, 32'(popped), 32'h1);
        pc_o = last_pop_pc;
    endtask

    initial begin
        total = 0;
        bad = 0;
        force_redir = 1'b0;
        force_target = 32'h0;
        lat_lo = 1; lat_hi = 1; rdy_pct = 100; idr_pct = 100; redir_pm = 0;
        @(negedge clk);
        do_reset();

        // Streaming from reset: first instruction presented two cycles after release.
        for (int i = 0; i < 4; i++) begin
            step();
            check("t1_valid", 32'(s_valid), 32'(i >= 2));
            if (i >= 2) check("t1_pc", s_pc, 32'(4 * (i - 2)));
        end

        // Decode stall: 0x8 held, requests stop once credit is used up.
        idr_pct = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t2_hold_pc", s_pc, 32'h8);
        end
        check("t2_req_low", 32'(s_req), 32'h0);
        idr_pct = 100;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t2_resume_valid", 32'(s_valid), 32'h1);
            check("t2_resume_pc", s_pc, 32'h8 + 32'(4 * i));
        end

        // Redirect with slow memory: in-flight words dropped, target comes next.
        lat_lo = 2; lat_hi = 2;
        for (int i = 0; i < 6; i++) step();
        force_redir = 1'b1;
        force_target = 32'h0000_0100;
        step();
        wait_pop("t3", got_pc);
        check("t3_first_pc", got_pc, 32'h0000_0100);

        // Redirect in the same cycle as a response and a pop, target near the top of memory.
        lat_lo = 1; lat_hi = 1;
        for (int i = 0; i < 6; i++) step();
        force_redir = 1'b1;
        force_target = 32'hFFFF_FFF8;
        step();
        check("t4_pop_in_redirect", 32'(s_valid), 32'h1);
        wait_pop("t4a", got_pc);
        check("t4_pc0", got_pc, 32'hFFFF_FFF8);
        wait_pop("t4b", got_pc);
        check("t4_pc1", got_pc, 32'hFFFF_FFFC);
        wait_pop("t4c", got_pc);
        check("t4_pc_wrap", got_pc, 32'h0000_0000);

        // Random traffic with a reset in the middle.
        lat_lo = 1; lat_hi = 3; rdy_pct = 50; idr_pct = 70; redir_pm = 20;
        for (int i = 0; i < 1500; i++) step();
        do_reset();
        redir_pm = 0;
        wait_pop("t5_after_rst", got_pc);
        check("t5_rst_pc", got_pc, 32'h0);
        redir_pm = 20;
        for (int i = 0; i < 1500; i++) step();
        rdy_pct = 100; idr_pct = 100; redir_pm = 0;
        wait_pop("t5_drain", got_pc);

`ifdef FETCH_PERF_EN
        do_reset();
        lat_lo = 1; lat_hi = 1; rdy_pct = 100;
        idr_pct = 0;
        for (int i = 0; i < 5; i++) step();
        idr_pct = 100;
        for (int i = 0; i < 10; i++) step();
        #1;
        check("t6_fetch_cnt", perf_fetch_cnt, 32'd10);
        check("t6_stall_cnt", perf_stall_cnt, 32'd3);
        do_reset();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
